// File: rtl/input_controller.sv
// input_controller: router input port that decodes, requests an output, and streams the packet (optional bad-destination dropping via INPUT_CTRL_DROP_BAD_DEST_EN)
module input_controller #(
  parameter int NUMBER_CHANNELS = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PORT_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [NUMBER_CHANNELS-1:0] req_channel,
  input  logic [NUMBER_CHANNELS-1:0] gnt_channel,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       eop,
  input  logic                       ack,
  output logic                       idle
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
  ,output logic [15:0]               drop_cnt
`endif
);
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_DROP} state_t;
  logic [15:0] drop_nxt;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;
`endif
  state_t state;
  logic [DATA_WIDTH-1:0] flit_reg;
  logic last_reg, full, hit, xfer, accept, dest_ok;
  logic [PORT_W-1:0] dest_in;
  logic [NUMBER_CHANNELS-1:0] dest_oh;
  // destination decode of the incoming header, handshake and output datapath
  always_comb begin
    dest_in = in_data[PORT_W-1:0];
    dest_ok = 32'(dest_in) < NUMBER_CHANNELS;
    dest_oh = dest_ok ? NUMBER_CHANNELS'(1) << dest_in : NUMBER_CHANNELS'(1);
    hit = |(gnt_channel & req_channel);
    out_valid = (state == S_SEND) & full & hit;
    xfer = out_valid & ack;
    eop = out_valid & last_reg;
    out_data = flit_reg;
    idle = state == S_IDLE;
    in_ready = ~rst & ((state == S_IDLE) | ((state == S_SEND) & ~last_reg & (~full | xfer)));
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
    in_ready = in_ready | (~rst & (state == S_DROP));
    drop_nxt = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
`endif
    accept = in_valid & in_ready;
  end
  // packet FSM: capture header, hold request until grant, stream with flow-through refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      flit_reg <= '0;
      last_reg <= 1'b0;
      full <= 1'b0;
      req_channel <= '0;
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
      drop_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
            if (!dest_ok) begin
              if (in_last) drop_cnt <= drop_nxt;
              else state <= S_DROP;
            end else begin
              flit_reg <= in_data;
              last_reg <= in_last;
              full <= 1'b1;
              req_channel <= dest_oh;
              state <= S_REQ;
            end
`else
            flit_reg <= in_data;
            last_reg <= in_last;
            full <= 1'b1;
            req_channel <= dest_oh;
            state <= S_REQ;
`endif
          end
        end
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
        S_DROP: begin
          if (accept && in_last) begin
            drop_cnt <= drop_nxt;
            state <= S_IDLE;
          end
        end
`endif
        default: begin
          if (xfer && last_reg) begin
            full <= 1'b0;
            req_channel <= '0;
            state <= S_IDLE;
          end else begin
            if (accept) begin
              flit_reg <= in_data;
              last_reg <= in_last;
              full <= 1'b1;
            end else if (xfer) begin
              full <= 1'b0;
            end
            if (state == S_REQ && hit) state <= S_SEND;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_controller.sv
// tb_input_controller: directed self-checking bench for input_controller
module tb_input_controller;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_ready, out_valid, eop, ack, idle;
  logic [31:0] in_data, out_data;
  logic [4:0] req_channel, gnt_channel;
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
  logic [15:0] drop_cnt;
`endif
  int checks = 0;
  int errors = 0;

  input_controller dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .req_channel(req_channel), .gnt_channel(gnt_channel),
    .out_valid(out_valid), .out_data(out_data), .eop(eop), .ack(ack), .idle(idle)
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_last = 0; gnt_channel = 0; ack = 0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idle", idle, 1);
    chk("rst_req", req_channel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_eop", eop, 0);
    tick; tick;
    rst = 0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 3-flit packet to port 2, grant two cycles after the request
    in_valid = 1; in_data = 32'hA0000002; in_last = 0; ack = 1;
    tick;
    in_data = 32'hA1000011; #1;
    chk("p3_req", req_channel, 32'b00100);
    chk("p3_req_in_ready", in_ready, 0);
    chk("p3_req_idle", idle, 0);
    tick; #1;
    chk("p3_wait1_valid", out_valid, 0);
    tick; gnt_channel = 5'b00100; #1;
    chk("p3_wait2_valid", out_valid, 0);
    tick; #1;
    chk("p3_f0_valid", out_valid, 1);
    chk("p3_f0_data", out_data, 32'hA0000002);
    chk("p3_f0_eop", eop, 0);
    chk("p3_f0_in_ready", in_ready, 1);
    tick; in_data = 32'hA2000022; in_last = 1; #1;
    chk("p3_f1_valid", out_valid, 1);
    chk("p3_f1_data", out_data, 32'hA1000011);
    chk("p3_f1_eop", eop, 0);
    tick; in_data = 32'hB0000004; in_last = 1; #1;
    chk("p3_f2_valid", out_valid, 1);
    chk("p3_f2_data", out_data, 32'hA2000022);
    chk("p3_f2_eop", eop, 1);
    chk("p3_f2_in_ready", in_ready, 0);
    tick; #1;
    chk("p3_end_idle", idle, 1);
    chk("p3_end_req", req_channel, 0);
    chk("p3_end_valid", out_valid, 0);
    chk("p3_end_in_ready", in_ready, 1);

    // single-flit packet to port 4, accepted in IDLE after the previous last flit
    tick; in_valid = 0; #1;
    chk("p1_req", req_channel, 32'b10000);
    chk("p1_stale_gnt_valid", out_valid, 0);
    gnt_channel = 5'b10000; #1;
    chk("p1_req_state_valid", out_valid, 0);
    tick; #1;
    chk("p1_valid", out_valid, 1);
    chk("p1_data", out_data, 32'hB0000004);
    chk("p1_eop", eop, 1);
    chk("p1_in_ready", in_ready, 0);
    tick; #1;
    chk("p1_end_idle", idle, 1);
    chk("p1_end_req", req_channel, 0);
    chk("p1_end_eop", eop, 0);

    // 4-flit packet to port 1 with ack low for 3 cycles
    gnt_channel = 5'b00010; in_valid = 1; in_data = 32'hC0000001; in_last = 0; ack = 1;
    tick;
    in_data = 32'hC1000011; #1;
    chk("bp_req", req_channel, 32'b00010);
    tick; #1;
    chk("bp_f0_valid", out_valid, 1);
    chk("bp_f0_data", out_data, 32'hC0000001);
    tick; in_data = 32'hC2000022; ack = 0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", out_data, 32'hC1000011);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      tick;
    end
    ack = 1; #1;
    chk("bp_resume_data", out_data, 32'hC1000011);
    chk("bp_resume_in_ready", in_ready, 1);
    tick; in_data = 32'hC3000033; in_last = 1; #1;
    chk("bp_f2_data", out_data, 32'hC2000022);
    chk("bp_f2_eop", eop, 0);
    tick; in_valid = 0; #1;
    chk("bp_f3_data", out_data, 32'hC3000033);
    chk("bp_f3_eop", eop, 1);
    tick; #1;
    chk("bp_end_idle", idle, 1);

    // 3-flit packet to port 3 with grant withdrawn for 2 cycles
    gnt_channel = 5'b01000; in_valid = 1; in_data = 32'hD0000003; in_last = 0;
    tick;
    in_data = 32'hD1000011; #1;
    tick; #1;
    chk("gw_f0_valid", out_valid, 1);
    chk("gw_f0_data", out_data, 32'hD0000003);
    tick; in_data = 32'hD2000022; in_last = 1; gnt_channel = 0; #1;
    chk("gw_off1_valid", out_valid, 0);
    chk("gw_off1_req", req_channel, 32'b01000);
    chk("gw_off1_data", out_data, 32'hD1000011);
    chk("gw_off1_in_ready", in_ready, 0);
    tick; #1;
    chk("gw_off2_valid", out_valid, 0);
    chk("gw_off2_req", req_channel, 32'b01000);
    chk("gw_off2_idle", idle, 0);
    tick; gnt_channel = 5'b01000; #1;
    chk("gw_on_valid", out_valid, 1);
    chk("gw_on_data", out_data, 32'hD1000011);
    chk("gw_on_in_ready", in_ready, 1);
    tick; in_valid = 0; #1;
    chk("gw_f2_data", out_data, 32'hD2000022);
    chk("gw_f2_eop", eop, 1);
    tick; #1;
    chk("gw_end_idle", idle, 1);

    // header with destination 7 on a 5-port switch
    gnt_channel = 0; in_valid = 1; in_data = 32'hE0000007; in_last = 0;
    tick;
    in_data = 32'hE1000011; in_last = 1; #1;
`ifdef INPUT_CTRL_DROP_BAD_DEST_EN
    chk("bad_drop_req", req_channel, 0);
    chk("bad_drop_idle", idle, 0);
    chk("bad_drop_in_ready", in_ready, 1);
    tick; in_valid = 0; #1;
    chk("bad_drop_cnt", drop_cnt, 1);
    chk("bad_drop_end_idle", idle, 1);
    chk("bad_drop_end_req", req_channel, 0);
`else
    chk("bad_req", req_channel, 32'b00001);
    gnt_channel = 5'b00001;
    tick; #1;
    chk("bad_f0_valid", out_valid, 1);
    chk("bad_f0_data", out_data, 32'hE0000007);
    chk("bad_f0_in_ready", in_ready, 1);
    tick; in_valid = 0; #1;
    chk("bad_f1_data", out_data, 32'hE1000011);
    chk("bad_f1_eop", eop, 1);
    tick; #1;
    chk("bad_end_idle", idle, 1);
`endif

    // asynchronous reset in the middle of a packet
    gnt_channel = 5'b00100; in_valid = 1; in_data = 32'hF0000002; in_last = 0;
    tick;
    in_data = 32'hF1000011;
    tick; #1;
    chk("mr_send_valid", out_valid, 1);
    #2 rst = 1; #1;
    chk("mr_req", req_channel, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_idle", idle, 1);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_eop", eop, 0);
    in_valid = 0;
    tick;
    rst = 0; #1;
    chk("mr_release_in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
